stepper_phase_decoder: RTL
==========================

Name: stepper_phase_decoder

Overview:
- Monitors the 4-bit half-step coil pattern driven to the curtain stepper motor.
- Decodes each legal pattern to a phase index and classifies each phase change as a forward step, a reverse step or a skipped step.
- Keeps a signed half-step position count of the curtain and flags illegal patterns and stalls.
- Sits on the motor output bus as the receive side, for closed-loop position feedback and self-check of the drive.

Parameters:
- STABLE_CYCLES, 4, consecutive clk edges a synchronized pattern must hold before it is accepted (1..255).
- POS_W, 16, width of the two's-complement position counter.
- STALL_CYCLES, 50000000, clk cycles without an accepted step before moving deasserts.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- coil_in  in  4  coil pattern from the motor drive; may be asynchronous to clk.
- clear  in  1  synchronous: zero position, clear sticky errors, return to UNLOCKED.
- position  out  POS_W  signed half-step count; forward = +1.
- phase_idx  out  3  index of the last accepted legal pattern.
- dir  out  1  direction of the last counted step: 1 = forward, 0 = reverse.
- step_pulse  out  1  one-cycle strobe per counted step.
- locked  out  1  a legal reference phase is held.
- moving  out  1  a step was counted within the last STALL_CYCLES cycles.
- err_illegal  out  1  sticky: a stable non-sequence pattern was seen.
- err_skip  out  1  sticky: a phase jump of 2..6 was seen.

Behaviour:
- Reset, asynchronous on rst high:
  - Outputs: position=0, phase_idx=0, dir=1, step_pulse=0, locked=0, moving=0, err_illegal=0, err_skip=0.
  - Internal: synchronizer=4'hF, candidate=4'hF, stability count=0, stall count=0.
- Input path: coil_in passes a 2-flop synchronizer (sync1, sync2).
- Stability filter:
  - When sync2 differs from the candidate: candidate<=sync2, count<=1.
  - Otherwise count increments, saturating at STABLE_CYCLES.
  - Accept occurs on the edge where count reaches STABLE_CYCLES. There is exactly one accept per stable run.
- Legal codes, index 0..7 in forward order: 7, 3, 11, 9, 13, 12, 14, 6. All other codes (including 15) are illegal.
- State UNLOCKED, on accept:
  - Legal code: phase_idx<=index, locked<=1, go LOCKED. No step is counted.
  - Illegal code: err_illegal<=1, stay UNLOCKED.
- State LOCKED, on accept, with d=(index-phase_idx) mod 8:
  - d=0: no action.
  - d=1: position+1, dir<=1, step_pulse.
  - d=7: position-1, dir<=0, step_pulse.
  - d=2..6: err_skip<=1, phase_idx<=index, position unchanged, no pulse.
  - Illegal code: err_illegal<=1. phase_idx and position are held and the state stays LOCKED.
  - On any legal accept, phase_idx<=index.
- Latency: new coil_in captured into sync1 at edge 0 → step_pulse, position, dir and phase_idx all updated at edge STABLE_CYCLES+2; step_pulse is high for exactly that one cycle.
- Glitch rejection: a pattern shorter than STABLE_CYCLES edges at sync2 is never accepted. Returning to the prior code after a glitch gives d=0, so no step is counted.
- Position arithmetic: modulo 2^POS_W. 0x7FFF+1 → 0x8000 with POS_W=16; 0-1 → all ones. No saturation.
- moving:
  - The stall counter resets to 0 and moving<=1 on each counted step.
  - Otherwise the counter increments; moving<=0 when it reaches STALL_CYCLES-1. The counter holds there.
- clear: takes effect at the next edge and overrides a simultaneous accept (that accept is discarded).
  - Zeroes position, the stall counter and moving.
  - Clears err_illegal and err_skip.
  - Sets locked=0 and returns to UNLOCKED.
  - The synchronizer and stability filter are unaffected. The current stable code is not re-accepted; relock needs the next change.
- Reset mid-step: all state is lost. After release, the first accepted legal code relocks without counting.

Test Plan:
- Lock then forward: after reset, hold 7 for 10 cycles, then drive 3, 11, 9, each held 10 cycles → locked=1 after the first accept, three step_pulses each at edge STABLE_CYCLES+2 after capture, position=3, dir=1, phase_idx=3.
- Reverse with wrap of the sequence: from locked at 7 (idx 0), drive 6 then 14 → position=-2 (0xFFFE), dir=0, phase_idx=6, no error flags.
- Glitch and illegal: while locked at 3, pulse 11 for 2 cycles then back to 3 → no pulse, position unchanged. Then hold 5 stable → err_illegal=1, phase_idx unchanged, locked=1.
- Skip: locked at 7 (idx 0), drive 13 (idx 4) → err_skip=1, phase_idx=4, no step_pulse. Next code 12 counts +1.
- Counter wrap and clear: preload position by 32767 forward steps, one more step → position=0x8000. Assert clear together with an accept → position=0, errors=0, locked=0, no pulse.
- Stall: with STALL_CYCLES=20, one step then hold → moving=1, then 0 on the 20th cycle after the step. Assert rst mid-run → all outputs at their reset values immediately.

Source files
------------

// File: rtl/stepper_phase_decoder.sv
// Receive-side decoder for the curtain stepper half-step coil bus.
// Filters the coil pattern, tracks phase and keeps a signed position.
module stepper_phase_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned POS_W         = 16,
    parameter int unsigned STALL_CYCLES  = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       coil_in,
    input  logic             clear,
    output logic [POS_W-1:0] position,
    output logic [2:0]       phase_idx,
    output logic             dir,
    output logic             step_pulse,
    output logic             locked,
    output logic             moving,
    output logic             err_illegal,
    output logic             err_skip
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned SW = $clog2(STALL_CYCLES + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES - 1);
    localparam logic [SW-1:0] STALL_ONE = SW'(1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_e;

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic [3:0]       acc_code_q, acc_code_d;

    state_e           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [2:0]       phase_q, phase_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             moving_q, moving_d;
    logic             err_ill_q, err_ill_d;
    logic             err_skip_q, err_skip_d;
    logic [SW-1:0]    stall_q, stall_d;

    logic             code_legal;
    logic [2:0]       code_idx;
    logic [2:0]       delta;

    // Synchronizer and stability filter: one accept strobe per stable run.
    always_comb begin
        sync1_d    = coil_in;
        sync2_d    = sync1_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        acc_d      = 1'b0;
        acc_code_d = sync2_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_ONE;
            acc_d  = (STABLE_CYCLES == 1);
        end else if (cnt_q != CNT_FULL) begin
            cnt_d = cnt_q + CNT_ONE;
            acc_d = (cnt_q == CNT_LAST);
        end
    end

    // Input path registers, reset to the all-ones idle pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 4'hF;
            sync2_q    <= 4'hF;
            cand_q     <= 4'hF;
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            acc_code_q <= 4'hF;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Map an accepted coil code to its half-step index in forward order.
    always_comb begin
        code_legal = 1'b1;
        code_idx   = 3'd0;
        unique case (acc_code_q)
            4'h7:    code_idx = 3'd0;
            4'h3:    code_idx = 3'd1;
            4'hB:    code_idx = 3'd2;
            4'h9:    code_idx = 3'd3;
            4'hD:    code_idx = 3'd4;
            4'hC:    code_idx = 3'd5;
            4'hE:    code_idx = 3'd6;
            4'h6:    code_idx = 3'd7;
            default: code_legal = 1'b0;
        endcase
    end

    // Lock/track FSM with position, error flags and stall tracking.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        phase_d    = phase_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        moving_d   = moving_q;
        err_ill_d  = err_ill_q;
        err_skip_d = err_skip_q;
        stall_d    = stall_q;
        delta      = code_idx - phase_q;

        if (clear) begin
            // A simultaneous accept is dropped entirely.
            state_d    = ST_UNLOCKED;
            pos_d      = '0;
            stall_d    = '0;
            moving_d   = 1'b0;
            err_ill_d  = 1'b0;
            err_skip_d = 1'b0;
        end else begin
            if (stall_q != STALL_MAX) begin
                stall_d = stall_q + STALL_ONE;
            end
            if (stall_d == STALL_MAX) begin
                moving_d = 1'b0;
            end

            if (acc_q) begin
                unique case (state_q)
                    ST_UNLOCKED: begin
                        if (code_legal) begin
                            phase_d = code_idx;
                            state_d = ST_LOCKED;
                        end else begin
                            err_ill_d = 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!code_legal) begin
                            err_ill_d = 1'b1;
                        end else begin
                            phase_d = code_idx;
                            unique case (1'b1)
                                (delta == 3'd0): begin
                                end
                                (delta == 3'd1): begin
                                    pos_d    = pos_q + POS_ONE;
                                    dir_d    = 1'b1;
                                    step_d   = 1'b1;
                                    stall_d  = '0;
                                    moving_d = 1'b1;
                                end
                                (delta == 3'd7): begin
                                    pos_d    = pos_q - POS_ONE;
                                    dir_d    = 1'b0;
                                    step_d   = 1'b1;
                                    stall_d  = '0;
                                    moving_d = 1'b1;
                                end
                                default: begin
                                    err_skip_d = 1'b1;
                                end
                            endcase
                        end
                    end
                    default: state_d = ST_UNLOCKED;
                endcase
            end
        end
    end

    // Tracking state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_UNLOCKED;
            pos_q      <= '0;
            phase_q    <= 3'd0;
            dir_q      <= 1'b1;
            step_q     <= 1'b0;
            moving_q   <= 1'b0;
            err_ill_q  <= 1'b0;
            err_skip_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            phase_q    <= phase_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            moving_q   <= moving_d;
            err_ill_q  <= err_ill_d;
            err_skip_q <= err_skip_d;
            stall_q    <= stall_d;
        end
    end

    assign position    = pos_q;
    assign phase_idx   = phase_q;
    assign dir         = dir_q;
    assign step_pulse  = step_q;
    assign locked      = (state_q == ST_LOCKED);
    assign moving      = moving_q;
    assign err_illegal = err_ill_q;
    assign err_skip    = err_skip_q;

endmodule
